// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, owner encoding and default widths for mem_arbiter.
package mem_arb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, loader and RAM signal bundle; slave = arbiter side, master = environment side.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = mem_arb_pkg::DATA_W,
  parameter int ADDR_WIDTH = mem_arb_pkg::ADDR_W
);
  logic                  cpu_req, cpu_write, cpu_ack;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata;
  logic                  ldr_req, ldr_write, ldr_ack;
  logic [ADDR_WIDTH-1:0] ldr_addr;
  logic [DATA_WIDTH-1:0] ldr_wdata, ldr_rdata;
  logic                  mem_read, mem_write, mem_enable, mem_done;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in, mem_data_out;
  logic                  busy, owner;
  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, ldr_req, ldr_write, ldr_addr, ldr_wdata,
           mem_data_out, mem_done,
    output cpu_rdata, cpu_ack, ldr_rdata, ldr_ack, mem_read, mem_write, mem_enable,
           mem_address, mem_data_in, busy, owner
  );
  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, ldr_req, ldr_write, ldr_addr, ldr_wdata,
           mem_data_out, mem_done,
    input  cpu_rdata, cpu_ack, ldr_rdata, ldr_ack, mem_read, mem_write, mem_enable,
           mem_address, mem_data_in, busy, owner
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational 2-way grant (bit 0 = CPU, bit 1 = loader); ties go away from last_owner unless CPU_PRIORITY.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant,
  output logic       valid
);
  always_comb begin
    valid = |req;
    grant = &req ? (CPU_PRIORITY ? OWN_CPU : ~last_owner) : req[OWN_LDR];
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU path and the loader port.
// Optional access watchdog with sticky timeout_err enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter bit CPU_PRIORITY   = 1'b0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic Clock,
  input logic reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);
  state_t state;
  logic wr, grant, valid, sel_write, to;
  logic [DATA_WIDTH-1:0] rword;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end
  rr_arbiter2 #(.CPU_PRIORITY(CPU_PRIORITY)) u_arb (
    .req       ({bus.ldr_req, bus.cpu_req}),
    .last_owner(bus.owner),
    .grant     (grant),
    .valid     (valid)
  );
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_comb to = (cnt == CW'(TIMEOUT_CYCLES - 1)) & ~bus.mem_done;
`else
  always_comb to = 1'b0;
`endif
  always_comb begin
    sel_write = grant ? bus.ldr_write : bus.cpu_write;
    rword     = to ? '1 : bus.mem_data_out;
  end
  always_ff @(posedge Clock or posedge reset)
    if (reset) begin
      state           <= IDLE;
      wr              <= 1'b0;
      bus.owner       <= OWN_LDR;
      bus.busy        <= 1'b0;
      bus.mem_enable  <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_data_in <= '0;
      bus.cpu_ack     <= 1'b0;
      bus.ldr_ack     <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.ldr_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt             <= '0;
      timeout_err     <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (valid) begin
            state           <= ACCESS;
            bus.owner       <= grant;
            wr              <= sel_write;
            bus.busy        <= 1'b1;
            bus.mem_enable  <= 1'b1;
            bus.mem_write   <= sel_write;
            bus.mem_read    <= ~sel_write;
            bus.mem_address <= grant ? bus.ldr_addr : bus.cpu_addr;
            bus.mem_data_in <= grant ? bus.ldr_wdata : bus.cpu_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt             <= '0;
`endif
          end
        ACCESS:
          if (bus.mem_done || to) begin
            state          <= RESPOND;
            bus.mem_enable <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.cpu_ack    <= ~bus.owner;
            bus.ldr_ack    <= bus.owner;
            // writes keep the old rdata unless the watchdog forces all ones
            if (to || !wr) begin
              if (bus.owner) bus.ldr_rdata <= rword;
              else bus.cpu_rdata <= rword;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            if (to) timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        RESPOND: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.cpu_ack <= 1'b0;
          bus.ldr_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and RAM against a transaction-timing reference model.
module tb_mem_arbiter;
  localparam int DW = 32, AW = 9, TO = 8;
  logic Clock = 1'b0, reset = 1'b1;
  always #5 Clock = ~Clock;
  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_err;
`endif
  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CPU_PRIORITY(1'b0), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock),
    .reset(reset),
    .bus  (bus.slave)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] ram[512];
  logic rq[2], rw[2];
  logic [AW-1:0] ra[2];
  logic [DW-1:0] rd[2];
  int cyc = 0, g = 0, lat = 0, eff = 0, free_at = 0, force_lat = 0, who = 0;
  bit act = 0, rnd = 0, tw = 0, lo = 1, te = 0;
  logic [AW-1:0] ta;
  logic [DW-1:0] td;

  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic apply(logic done, logic [DW-1:0] dout);
    bus.cpu_req = rq[0]; bus.cpu_write = rw[0]; bus.cpu_addr = ra[0]; bus.cpu_wdata = rd[0];
    bus.ldr_req = rq[1]; bus.ldr_write = rw[1]; bus.ldr_addr = ra[1]; bus.ldr_wdata = rd[1];
    bus.mem_done = done; bus.mem_data_out = dout;
  endtask

  task automatic model_reset();
    act = 0; lo = 1; te = 0; free_at = 0; force_lat = 0;
    for (int i = 0; i < 2; i++) begin rq[i] = 0; rw[i] = 0; ra[i] = '0; rd[i] = '0; end
    apply(1'b0, '0);
  endtask

  task automatic raise(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    rq[i] = 1; rw[i] = w; ra[i] = a; rd[i] = d;
    apply(1'b0, $urandom());
  endtask

  // Timing model: a grant at edge g with done latency lat occupies edges g..g+lat
  // (ack visible after edge g+lat) and the next grant can happen at edge g+lat+2.
  task automatic step();
    logic d;
    logic [DW-1:0] dout;
    bit en, ak;
    @(posedge Clock);
    cyc++;
    if (act && cyc > g + eff) act = 0;
    if (!act && cyc >= free_at && (rq[0] || rq[1])) begin
      who = (rq[0] && rq[1]) ? int'(!lo) : (rq[1] ? 1 : 0);
      lo = who[0]; tw = rw[who]; ta = ra[who]; td = rd[who]; g = cyc;
      lat = force_lat > 0 ? force_lat : $urandom_range(1, 4);
      force_lat = 0;
      eff = lat > TO ? TO : lat;
      free_at = g + eff + 2;
      act = 1;
    end
    @(negedge Clock);
    en = act && cyc < g + eff;
    ak = act && cyc == g + eff;
    check("busy", bus.busy, act);
    check("mem_enable", bus.mem_enable, en);
    check("mem_read", bus.mem_read, en && !tw);
    check("mem_write", bus.mem_write, en && tw);
    check("cpu_ack", bus.cpu_ack, ak && who == 0);
    check("ldr_ack", bus.ldr_ack, ak && who == 1);
    check("owner", bus.owner, lo);
    if (en) check("mem_address", bus.mem_address, ta);
    if (en && tw) check("mem_data_in", bus.mem_data_in, td);
    if (ak) begin
      if (lat > TO) begin
        check("rdata_timeout", who ? bus.ldr_rdata : bus.cpu_rdata, '1);
        te = 1;
      end else if (!tw) check("rdata", who ? bus.ldr_rdata : bus.cpu_rdata, ram[ta]);
      else ram[ta] = td;
      rq[who] = 0;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("timeout_err", timeout_err, te);
`endif
    if (rnd)
      for (int i = 0; i < 2; i++) begin
        if (!rq[i]) begin
          if (!ak && $urandom_range(0, 2) == 0) begin
            rq[i] = 1; rw[i] = 1'($urandom_range(0, 1));
            ra[i] = AW'($urandom_range(0, 15)); rd[i] = $urandom();
          end
        end else if (act && who == i) begin
          if ($urandom_range(0, 2) == 0) begin
            rw[i] = 1'($urandom_range(0, 1)); ra[i] = AW'($urandom()); rd[i] = $urandom();
          end
        end else if ($urandom_range(0, 9) == 0) rq[i] = 0;
      end
    if (act && cyc + 1 <= g + eff) begin
      d = (cyc + 1 == g + lat);
      dout = (d && !tw) ? ram[ta] : $urandom();
    end else begin
      d = 1'($urandom_range(0, 1));
      dout = $urandom();
    end
    apply(d, dout);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = $urandom();
    model_reset();
    @(negedge Clock);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_enable", bus.mem_enable, 1'b0);
    check("rst_read", bus.mem_read, 1'b0);
    check("rst_write", bus.mem_write, 1'b0);
    check("rst_cpu_ack", bus.cpu_ack, 1'b0);
    check("rst_ldr_ack", bus.ldr_ack, 1'b0);
    check("rst_owner", bus.owner, 1'b1);
    check("rst_cpu_rdata", bus.cpu_rdata, '0);
    check("rst_ldr_rdata", bus.ldr_rdata, '0);
    check("rst_address", bus.mem_address, '0);
    check("rst_data_in", bus.mem_data_in, '0);
    reset = 0;
    // CPU read with done on the second ACCESS cycle
    ram[5] = 32'hDEADBEEF;
    force_lat = 2;
    raise(0, 1'b0, 9'h005, '0);
    repeat (6) step();
    // loader write to the top address, then CPU reads it back
    raise(1, 1'b1, 9'h1FF, 32'h12345678);
    repeat (6) step();
    raise(0, 1'b0, 9'h1FF, '0);
    repeat (6) step();
    // simultaneous requests right after reset, twice
    reset = 1;
    model_reset();
    @(negedge Clock);
    reset = 0;
    for (int k = 0; k < 2; k++) begin
      raise(0, 1'b0, AW'(k + 1), '0);
      raise(1, 1'b1, AW'(k + 8), $urandom());
      repeat (14) step();
    end
    // asynchronous reset in the middle of an access
    force_lat = 6;
    raise(0, 1'b0, 9'h00A, '0);
    repeat (3) step();
    #2 reset = 1;
    #1;
    check("arst_enable", bus.mem_enable, 1'b0);
    check("arst_read", bus.mem_read, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_owner", bus.owner, 1'b1);
    model_reset();
    @(negedge Clock);
    reset = 0;
    repeat (4) step();
    raise(0, 1'b1, 9'h00C, $urandom());
    repeat (6) step();
    raise(1, 1'b0, 9'h00C, '0);
    repeat (6) step();
`ifdef MEM_ARB_TIMEOUT_EN
    force_lat = 40;
    raise(0, 1'b0, 9'h003, '0);
    repeat (14) step();
    check("timeout_sticky", timeout_err, 1'b1);
`endif
    rnd = 1;
    repeat (1500) step();
    rnd = 0;
    repeat (30) step();
    check("drain_busy", bus.busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
